dram_rd_arbiter: RTL and testbench

- Shares the single DRAM block-read port (dram_ctrl_sim) between the I-cache and D-cache refill engines.
- Each burst returns BLOCK_WIDTH words.
- Grants one requester at a time, round-robin on ties, and converts level requests into the single-cycle request pulse the controller expects.
- Routes returned beats to the granted requester, and signals done, or error on timeout.

---
 rtl/dram_arb_pkg.sv | 10 +
 rtl/rr_arb2.sv | 23 ++
 rtl/dram_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_dram_rd_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM block-read port arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, RELEASE} state_t;

    localparam int REQ_IC = 0;
    localparam int REQ_DC = 1;
    localparam int NREQ   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_arb2
    import dram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] gnt
);

    // last is the index of the previous owner (0 = I-cache, 1 = D-cache)
    always_comb begin
        gnt = req;
        if (req[REQ_IC] && req[REQ_DC]) begin
            gnt = '0;
            if (last) begin
                gnt[REQ_IC] = 1'b1;
            end else begin
                gnt[REQ_DC] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Shares the DRAM block-read port between the I-cache and D-cache refill engines,
// issuing a one-cycle request pulse and steering the returned beats to the owner.
module dram_rd_arbiter
    import dram_arb_pkg::*;
#(
    parameter int BLOCK_WIDTH = 8,
    parameter int TIMEOUT     = 64,
    parameter int AW          = 32
) (
    input  logic          clock,
    input  logic          rst,

    input  logic          ic_rd_req,
    input  logic [AW-1:0] ic_rd_address,
    output logic          ic_rd_vld,
    output logic [31:0]   ic_rd_data,
    output logic          ic_rd_done,
    output logic          ic_rd_err,

    input  logic          dc_rd_req,
    input  logic [AW-1:0] dc_rd_address,
    output logic          dc_rd_vld,
    output logic [31:0]   dc_rd_data,
    output logic          dc_rd_done,
    output logic          dc_rd_err,

    output logic          dram_rd_req,
    output logic [AW-1:0] dram_rd_address,
    input  logic          dram_rd_vld,
    input  logic [31:0]   dram_rd_data,

    output logic          busy,
    output logic [1:0]    grant
);

    localparam int BEAT_W = $clog2(BLOCK_WIDTH);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WIDTH - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [AW-1:0]     ADDR_MASK = ~AW'(BLOCK_WIDTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     pick;
    logic [AW-1:0]       sel_addr;
    logic                last_dc;
    logic                ok;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                in_burst;
    logic                in_release;

    assign req      = {dc_rd_req, ic_rd_req};
    assign sel_addr = pick[REQ_DC] ? dc_rd_address : ic_rd_address;

    rr_arb2 u_rr (
        .req  (req),
        .last (last_dc),
        .gnt  (pick)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = BURST;
            BURST: begin
                if (dram_rd_vld ? (beat_cnt == BEAT_LAST) : (tmo_cnt == TMO_LAST)) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The request pulse is registered from ISSUE so the controller always sees a clean 0->1 edge
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            grant           <= '0;
            last_dc         <= 1'b1;
            ok              <= 1'b0;
            dram_rd_req     <= 1'b0;
            dram_rd_address <= '0;
            beat_cnt        <= '0;
            tmo_cnt         <= '0;
        end else begin
            dram_rd_req <= (state == ISSUE);
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant           <= pick;
                        dram_rd_address <= sel_addr & ADDR_MASK;
                    end
                end
                ISSUE: begin
                    beat_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                BURST: begin
                    if (dram_rd_vld) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        tmo_cnt  <= '0;
                        ok       <= (beat_cnt == BEAT_LAST);
                    end else if (tmo_cnt == TMO_LAST) begin
                        ok <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    last_dc <= grant[REQ_DC];
                    grant   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign in_burst   = (state == BURST);
    assign in_release = (state == RELEASE);
    assign busy       = (state != IDLE);

    // Beats outside BURST are dropped here; the counters above ignore them too
    assign ic_rd_vld  = dram_rd_vld & grant[REQ_IC] & in_burst;
    assign dc_rd_vld  = dram_rd_vld & grant[REQ_DC] & in_burst;
    assign ic_rd_data = dram_rd_data;
    assign dc_rd_data = dram_rd_data;

    assign ic_rd_done = in_release &  ok & grant[REQ_IC];
    assign dc_rd_done = in_release &  ok & grant[REQ_DC];
    assign ic_rd_err  = in_release & ~ok & grant[REQ_IC];
    assign dc_rd_err  = in_release & ~ok & grant[REQ_DC];

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Randomized bench for dram_rd_arbiter: requester engines and a DRAM stub drive the DUT,
// a transaction-level model predicts every output cycle by cycle.
module tb_dram_rd_arbiter;

    localparam int BW  = 8;
    localparam int TMO = 64;
    localparam int AW  = 32;

    logic          clock = 1'b0;
    logic          rst   = 1'b0;
    logic          ic_rd_req = 1'b0;
    logic [AW-1:0] ic_rd_address = '0;
    logic          ic_rd_vld, ic_rd_done, ic_rd_err;
    logic [31:0]   ic_rd_data;
    logic          dc_rd_req = 1'b0;
    logic [AW-1:0] dc_rd_address = '0;
    logic          dc_rd_vld, dc_rd_done, dc_rd_err;
    logic [31:0]   dc_rd_data;
    logic          dram_rd_req;
    logic [AW-1:0] dram_rd_address;
    logic          dram_rd_vld = 1'b0;
    logic [31:0]   dram_rd_data = '0;
    logic          busy;
    logic [1:0]    grant;

    always #5 clock = ~clock;

    dram_rd_arbiter #(.BLOCK_WIDTH(BW), .TIMEOUT(TMO), .AW(AW)) dut (
        .clock(clock), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_address(ic_rd_address), .ic_rd_vld(ic_rd_vld),
        .ic_rd_data(ic_rd_data), .ic_rd_done(ic_rd_done), .ic_rd_err(ic_rd_err),
        .dc_rd_req(dc_rd_req), .dc_rd_address(dc_rd_address), .dc_rd_vld(dc_rd_vld),
        .dc_rd_data(dc_rd_data), .dc_rd_done(dc_rd_done), .dc_rd_err(dc_rd_err),
        .dram_rd_req(dram_rd_req), .dram_rd_address(dram_rd_address),
        .dram_rd_vld(dram_rd_vld), .dram_rd_data(dram_rd_data),
        .busy(busy), .grant(grant)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // requester engines (index 0 = I-cache, 1 = D-cache)
    bit          rq [2];
    logic [31:0] raddr [2];
    bit          auto_en [2];
    bit          hold [2];
    bit          force_raise [2];
    logic [31:0] force_addr [2];
    int          idle_cnt [2];
    bit          saw_end [2];

    // DRAM controller stub
    bit          stub_go = 0;
    bit          stub_active = 0;
    logic [31:0] stub_base = '0;
    int          stub_sent = 0;
    int          stub_gap = 0;
    int          stub_limit = BW;
    bit          stray_en = 0;

    // transaction-level reference model
    bit          m_active = 0;
    bit          m_last = 1;
    bit          m_ok = 0;
    int          m_owner = 0;
    int          m_dec = 0;
    int          m_end_at = -1;
    int          m_beats = 0;
    int          m_silent = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_addr_hold = '0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (saw_end[r]) begin
                saw_end[r] = 0;
                if (hold[r]) begin
                    raddr[r] = $urandom;
                    hold[r]  = auto_en[r] && ($urandom_range(2) == 0);
                end else begin
                    rq[r]       = 0;
                    idle_cnt[r] = $urandom_range(6);
                end
            end else if (!rq[r]) begin
                if (force_raise[r]) begin
                    rq[r]          = 1;
                    raddr[r]       = force_addr[r];
                    force_raise[r] = 0;
                end else if (auto_en[r]) begin
                    if (idle_cnt[r] == 0) begin
                        rq[r]    = 1;
                        raddr[r] = $urandom;
                        hold[r]  = ($urandom_range(2) == 0);
                    end else begin
                        idle_cnt[r]--;
                    end
                end
            end
        end
        ic_rd_req     = rq[0];
        ic_rd_address = raddr[0];
        dc_rd_req     = rq[1];
        dc_rd_address = raddr[1];

        dram_rd_vld  = 1'b0;
        dram_rd_data = $urandom;
        if (stub_go) begin
            stub_go     = 0;
            stub_active = 1;
            stub_sent   = 0;
            stub_gap    = $urandom_range(3);
        end
        if (stub_active) begin
            if (stub_gap > 0) begin
                stub_gap--;
            end else if (stub_sent < stub_limit) begin
                dram_rd_vld  = 1'b1;
                dram_rd_data = memw(stub_base + 32'(stub_sent));
                stub_sent++;
                stub_gap = $urandom_range(3);
                if (stub_sent == BW) stub_active = 0;
            end
        end else if (stray_en) begin
            dram_rd_vld = 1'b1;
        end
    endtask

    task automatic check_cycle();
        logic [1:0]  e_grant = '0;
        logic [1:0]  e_vld = '0;
        logic [1:0]  e_done = '0;
        logic [1:0]  e_err = '0;
        logic        e_busy = 1'b0;
        logic        e_dreq = 1'b0;
        logic [31:0] e_data = '0;
        bit          fin = 0;
        int          d;
        if (m_active) begin
            d       = cyc - m_dec;
            e_busy  = 1'b1;
            e_grant = 2'(1 << m_owner);
            if (m_end_at == cyc) begin
                if (m_ok) e_done[m_owner] = 1'b1;
                else      e_err[m_owner]  = 1'b1;
                fin = 1;
            end else if (d >= 2) begin
                e_dreq = (d == 2);
                if (dram_rd_vld) begin
                    e_vld[m_owner] = 1'b1;
                    e_data   = memw(m_addr + 32'(m_beats));
                    m_beats++;
                    m_silent = 0;
                    if (m_beats == BW) begin
                        m_end_at = cyc + 1;
                        m_ok     = 1;
                    end
                end else begin
                    m_silent++;
                    if (m_silent == TMO) begin
                        m_end_at = cyc + 1;
                        m_ok     = 0;
                    end
                end
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant", 32'(grant), 32'(e_grant));
        chk("dram_req", 32'(dram_rd_req), 32'(e_dreq));
        chk("dram_addr", dram_rd_address, m_addr_hold);
        chk("ic_vld", 32'(ic_rd_vld), 32'(e_vld[0]));
        chk("dc_vld", 32'(dc_rd_vld), 32'(e_vld[1]));
        chk("ic_done", 32'(ic_rd_done), 32'(e_done[0]));
        chk("dc_done", 32'(dc_rd_done), 32'(e_done[1]));
        chk("ic_err", 32'(ic_rd_err), 32'(e_err[0]));
        chk("dc_err", 32'(dc_rd_err), 32'(e_err[1]));
        if (e_vld[0]) chk("ic_data", ic_rd_data, e_data);
        if (e_vld[1]) chk("dc_data", dc_rd_data, e_data);

        if (dram_rd_req) begin
            stub_go   = 1;
            stub_base = dram_rd_address;
        end
        if (ic_rd_done || ic_rd_err) saw_end[0] = 1;
        if (dc_rd_done || dc_rd_err) saw_end[1] = 1;

        if (fin) begin
            m_active = 0;
            m_last   = (m_owner == 1);
        end else if (!m_active && rst && (ic_rd_req || dc_rd_req)) begin
            if (ic_rd_req && dc_rd_req) m_owner = m_last ? 0 : 1;
            else                        m_owner = ic_rd_req ? 0 : 1;
            m_addr      = (m_owner == 0 ? ic_rd_address : dc_rd_address) & ~32'(BW - 1);
            m_addr_hold = m_addr;
            m_active    = 1;
            m_dec       = cyc;
            m_beats     = 0;
            m_silent    = 0;
            m_end_at    = -1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        #1 drive();
        @(negedge clock);
        check_cycle();
    endtask

    function automatic bit is_free();
        return !m_active && !rq[0] && !rq[1] && !force_raise[0] && !force_raise[1];
    endfunction

    task automatic run_until_free(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (is_free()) return;
        end
        chk("wait_bound", 32'(is_free()), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 0; raddr[r] = '0; auto_en[r] = 0; hold[r] = 0;
            force_raise[r] = 0; force_addr[r] = '0; idle_cnt[r] = 0; saw_end[r] = 0;
        end

        repeat (3) step();
        rst = 1'b1;
        step();

        // I-cache alone on an unaligned address
        force_addr[0] = 32'h103; force_raise[0] = 1;
        run_until_free(200);

        // stray beats while idle
        stray_en = 1;
        repeat (6) step();
        stray_en = 0;
        step();

        // controller stalls after three beats
        stub_limit = 3;
        force_addr[1] = 32'h2345; force_raise[1] = 1;
        run_until_free(400);
        stub_limit  = BW;
        stub_active = 0;
        repeat (3) step();

        // reset asserted in the middle of a burst
        force_addr[0] = 32'h4567; force_raise[0] = 1;
        n = 0;
        while (!(m_active && m_beats == 4) && n < 200) begin
            step();
            n++;
        end
        chk("beat4_reached", 32'(m_beats), 32'd4);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_dram_req", 32'(dram_rd_req), 32'd0);
        chk("rst_dram_addr", dram_rd_address, 32'd0);
        chk("rst_ic_vld", 32'(ic_rd_vld), 32'd0);
        chk("rst_ic_done_err", 32'({ic_rd_done, ic_rd_err}), 32'd0);
        m_active = 0; m_last = 1; m_addr_hold = '0;
        stub_active = 0; stub_go = 0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 0; saw_end[r] = 0; force_raise[r] = 0; hold[r] = 0;
        end
        repeat (3) step();
        rst = 1'b1;
        step();

        // simultaneous requests; I-cache keeps its request up across done
        hold[0] = 1;
        force_addr[0] = 32'h808; force_raise[0] = 1;
        force_addr[1] = 32'hC0C; force_raise[1] = 1;
        run_until_free(600);

        // random traffic from both requesters
        auto_en[0] = 1; auto_en[1] = 1;
        idle_cnt[0] = 0; idle_cnt[1] = 0;
        repeat (3000) step();
        auto_en[0] = 0; auto_en[1] = 0;
        run_until_free(1000);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
